me_search_ctrl: RTL and testbench

Parametrised sequencing controller for the full-search block-matching motion-estimation array. It steps a single index counter through one reference block and every vertical candidate position. From that index it drives the PE array's distortion-restart, ready and operand-select strobes, the reference and dual search-window memory addresses, and the motion-vector tag. Compared with the fixed 16×16 controller it adds generic block size and vertical search depth, an explicit IDLE/RUN/DONE handshake, registered outputs and a reset.

---
 rtl/me_pkg.sv | 34 +++
 rtl/me_addr_gen.sv | 71 +++++++
 rtl/me_search_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_me_search_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
// Module   : me_pkg
// Purpose  : Shared types and size helpers for the motion-estimation
//            search controller (state encoding, window width, run length,
//            search-window address width).
// Revision : 1.0  initial release
// ============================================================================
package me_pkg;

  // Controller states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    ME_IDLE = 2'd0,
    ME_RUN  = 2'd1,
    ME_DONE = 2'd2
  } me_state_e;

  // Search-window width: every horizontal offset of a block
  function automatic int me_w(input int blk);
    return 2 * blk - 1;
  endfunction

  // Index count of one run: all vertical positions plus one block row of drain
  function automatic int me_total(input int blk, input int vpos);
    return vpos * blk * blk + blk;
  endfunction

  // Address width covering the full (BLK+VPOS-1) x W search window
  function automatic int me_aw(input int blk, input int vpos);
    return $clog2((blk + vpos - 1) * me_w(blk));
  endfunction

endpackage
`default_nettype wire

// File: rtl/me_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : me_addr_gen
// Purpose  : Pure combinational decode of the search index k into the
//            reference address, both search-window addresses and the
//            motion-vector tags.
// Revision : 1.0  initial release
// ============================================================================
module me_addr_gen
  import me_pkg::*;
#(
  parameter int BLK  = 16,
  parameter int VPOS = 16,
  parameter int B    = $clog2(BLK),
  parameter int V    = $clog2(VPOS),
  parameter int AW   = me_aw(BLK, VPOS),
  parameter int KW   = $clog2(me_total(BLK, VPOS))
) (
  input  logic [KW-1:0]  i_k,
  output logic [2*B-1:0] o_address_r,
  output logic [AW-1:0]  o_address_s1,
  output logic [AW-1:0]  o_address_s2,
  output logic [B:0]     o_vector_x,
  output logic [V:0]     o_vector_y
);

  localparam int            c_W       = me_w(BLK);
  localparam int            c_FW      = 2 * B + V;
  localparam logic [KW-1:0] c_NSEARCH = KW'(VPOS * BLK * BLK);
  localparam logic [KW-1:0] c_BLK_K   = KW'(BLK);

  logic [B-1:0]    w_col;
  logic [B-1:0]    w_row;
  logic [V-1:0]    w_vp;
  logic [c_FW-1:0] w_t;
  logic [B-1:0]    w_t_col;
  logic [B-1:0]    w_t_row;
  logic [V-1:0]    w_t_vp;

  assign w_col = i_k[B-1:0];
  assign w_row = i_k[2*B-1:B];
  assign w_vp  = i_k[c_FW-1:2*B];

  // Port 2 lags port 1 by one block row; modular subtraction is exact
  // whenever k >= BLK, the only case in which port 2 is used.
  assign w_t     = i_k[c_FW-1:0] - c_FW'(BLK);
  assign w_t_col = w_t[B-1:0];
  assign w_t_row = w_t[2*B-1:B];
  assign w_t_vp  = w_t[c_FW-1:2*B];

  assign o_address_r = i_k[2*B-1:0];

  // Window addresses, evaluated at AW bits where every product already fits
  always_comb begin
    o_address_s1 = '0;
    o_address_s2 = '0;
    if (i_k < c_NSEARCH) begin
      o_address_s1 = (AW'(w_vp) + AW'(w_row)) * AW'(c_W) + AW'(w_col);
    end
    if (i_k >= c_BLK_K) begin
      o_address_s2 = (AW'(w_t_vp) + AW'(w_t_row)) * AW'(c_W)
                   + AW'(w_t_col) + AW'(BLK);
    end
  end

  // Signed displacement tags, wrapping in their own width
  assign o_vector_x = (B+1)'(w_col) - (B+1)'(BLK / 2);
  assign o_vector_y = (V+1)'(w_vp) - (V+1)'(1) - (V+1)'(VPOS / 2);

endmodule
`default_nettype wire

// File: rtl/me_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : me_search_ctrl
// Purpose  : Full-search block-matching sequencing controller. Steps one
//            index through the reference block and all vertical candidates,
//            driving PE strobes, memory addresses and motion-vector tags
//            from registered outputs.
// Options  : ME_SEARCH_ABORT_EN adds an abort input that cancels a run.
// Revision : 1.0  initial release
// ============================================================================
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int BLK  = 16,
  parameter int VPOS = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
`ifdef ME_SEARCH_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [BLK-1:0]                new_dist,
  output logic [BLK-1:0]                pe_ready,
  output logic [BLK-1:0]                s1s2_mux,
  output logic                          comp_start,
  output logic [$clog2(BLK):0]          vector_x,
  output logic [$clog2(VPOS):0]         vector_y,
  output logic [2*$clog2(BLK)-1:0]      address_r,
  output logic [me_aw(BLK, VPOS)-1:0]   address_s1,
  output logic [me_aw(BLK, VPOS)-1:0]   address_s2
);

  localparam int              c_B     = $clog2(BLK);
  localparam int              c_V     = $clog2(VPOS);
  localparam int              c_AW    = me_aw(BLK, VPOS);
  localparam int              c_TOTAL = me_total(BLK, VPOS);
  localparam int              c_KW    = $clog2(c_TOTAL);
  localparam logic [c_KW-1:0] c_LAST  = c_KW'(c_TOTAL - 1);
  localparam logic [c_KW-1:0] c_NCOMP = c_KW'(BLK * BLK);

  me_state_e         r_state;
  me_state_e         w_state_nxt;
  logic [c_KW-1:0]   r_k;
  logic [c_KW-1:0]   w_k_nxt;
  logic              w_abort;

  // Decode of the current index
  logic [BLK-1:0]    w_nd;
  logic [BLK-1:0]    w_mux;
  logic              w_cs;
  logic [c_B:0]      w_vx;
  logic [c_V:0]      w_vy;
  logic [2*c_B-1:0]  w_ar;
  logic [c_AW-1:0]   w_s1;
  logic [c_AW-1:0]   w_s2;

  // Next output values
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [BLK-1:0]    w_nd_nxt;
  logic [BLK-1:0]    w_rdy_nxt;
  logic [BLK-1:0]    w_mux_nxt;
  logic              w_cs_nxt;
  logic [c_B:0]      w_vx_nxt;
  logic [c_V:0]      w_vy_nxt;
  logic [2*c_B-1:0]  w_ar_nxt;
  logic [c_AW-1:0]   w_s1_nxt;
  logic [c_AW-1:0]   w_s2_nxt;

  // Output registers
  logic              r_busy;
  logic              r_done;
  logic [BLK-1:0]    r_nd;
  logic [BLK-1:0]    r_rdy;
  logic [BLK-1:0]    r_mux;
  logic              r_cs;
  logic [c_B:0]      r_vx;
  logic [c_V:0]      r_vy;
  logic [2*c_B-1:0]  r_ar;
  logic [c_AW-1:0]   r_s1;
  logic [c_AW-1:0]   r_s2;

`ifdef ME_SEARCH_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  me_addr_gen #(
    .BLK  (BLK),
    .VPOS (VPOS),
    .B    (c_B),
    .V    (c_V),
    .AW   (c_AW),
    .KW   (c_KW)
  ) u_addr_gen (
    .i_k          (r_k),
    .o_address_r  (w_ar),
    .o_address_s1 (w_s1),
    .o_address_s2 (w_s2),
    .o_vector_x   (w_vx),
    .o_vector_y   (w_vy)
  );

  // Per-PE strobes: restart on the PE's own in-block offset, s1 for col >= i
  always_comb begin
    w_nd  = '0;
    w_mux = '0;
    for (int i = 0; i < BLK; i++) begin
      w_nd[i]  = (w_ar == (2*c_B)'(i));
      w_mux[i] = (r_k[c_B-1:0] >= c_B'(i));
    end
  end

  // The comparator starts once the first candidate row has been accumulated
  assign w_cs = (r_k >= c_NCOMP);

  // Next-state, next-index and next-output decode; IDLE drives all zeros
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = '0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_nd_nxt    = '0;
    w_rdy_nxt   = '0;
    w_mux_nxt   = '0;
    w_cs_nxt    = 1'b0;
    w_vx_nxt    = '0;
    w_vy_nxt    = '0;
    w_ar_nxt    = '0;
    w_s1_nxt    = '0;
    w_s2_nxt    = '0;
    case (r_state)
      ME_IDLE: begin
        if (start) begin
          w_state_nxt = ME_RUN;
        end
      end
      ME_RUN: begin
        if (w_abort) begin
          w_state_nxt = ME_IDLE;
        end else begin
          w_busy_nxt = 1'b1;
          w_nd_nxt   = w_nd;
          w_rdy_nxt  = w_nd & {BLK{w_cs}};
          w_mux_nxt  = w_mux;
          w_cs_nxt   = w_cs;
          w_vx_nxt   = w_vx;
          w_vy_nxt   = w_vy;
          w_ar_nxt   = w_ar;
          w_s1_nxt   = w_s1;
          w_s2_nxt   = w_s2;
          if (r_k == c_LAST) begin
            w_state_nxt = ME_DONE;
          end else begin
            w_k_nxt = r_k + c_KW'(1);
          end
        end
      end
      ME_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ME_IDLE;
      end
      default: begin
        w_state_nxt = ME_IDLE;
      end
    endcase
  end

  // State and index register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ME_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_nd   <= '0;
      r_rdy  <= '0;
      r_mux  <= '0;
      r_cs   <= 1'b0;
      r_vx   <= '0;
      r_vy   <= '0;
      r_ar   <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_nd   <= w_nd_nxt;
      r_rdy  <= w_rdy_nxt;
      r_mux  <= w_mux_nxt;
      r_cs   <= w_cs_nxt;
      r_vx   <= w_vx_nxt;
      r_vy   <= w_vy_nxt;
      r_ar   <= w_ar_nxt;
      r_s1   <= w_s1_nxt;
      r_s2   <= w_s2_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign new_dist   = r_nd;
  assign pe_ready   = r_rdy;
  assign s1s2_mux   = r_mux;
  assign comp_start = r_cs;
  assign vector_x   = r_vx;
  assign vector_y   = r_vy;
  assign address_r  = r_ar;
  assign address_s1 = r_s1;
  assign address_s2 = r_s2;

endmodule
`default_nettype wire

// File: tb/tb_me_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_search_ctrl
// Purpose  : Directed self-checking bench. Instance A is BLK=16/VPOS=16,
//            instance B is BLK=8/VPOS=8; both share clock and reset.
// Options  : ME_SEARCH_ABORT_EN enables the abort scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_me_search_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  // Instance A signals (BLK=16, VPOS=16: AW=10)
  logic        a_start = 1'b0;
  logic        a_abort = 1'b0;
  logic        a_busy, a_done, a_comp_start;
  logic [15:0] a_new_dist, a_pe_ready, a_s1s2_mux;
  logic [4:0]  a_vector_x, a_vector_y;
  logic [7:0]  a_address_r;
  logic [9:0]  a_address_s1, a_address_s2;

  // Instance B signals (BLK=8, VPOS=8: AW=8)
  logic        b_start = 1'b0;
  logic        b_abort = 1'b0;
  logic        b_busy, b_done, b_comp_start;
  logic [7:0]  b_new_dist, b_pe_ready, b_s1s2_mux;
  logic [3:0]  b_vector_x, b_vector_y;
  logic [5:0]  b_address_r;
  logic [7:0]  b_address_s1, b_address_s2;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  me_search_ctrl #(.BLK(16), .VPOS(16)) u_dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (a_start),
`ifdef ME_SEARCH_ABORT_EN
    .abort      (a_abort),
`endif
    .busy       (a_busy),
    .done       (a_done),
    .new_dist   (a_new_dist),
    .pe_ready   (a_pe_ready),
    .s1s2_mux   (a_s1s2_mux),
    .comp_start (a_comp_start),
    .vector_x   (a_vector_x),
    .vector_y   (a_vector_y),
    .address_r  (a_address_r),
    .address_s1 (a_address_s1),
    .address_s2 (a_address_s2)
  );

  me_search_ctrl #(.BLK(8), .VPOS(8)) u_dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (b_start),
`ifdef ME_SEARCH_ABORT_EN
    .abort      (b_abort),
`endif
    .busy       (b_busy),
    .done       (b_done),
    .new_dist   (b_new_dist),
    .pe_ready   (b_pe_ready),
    .s1s2_mux   (b_s1s2_mux),
    .comp_start (b_comp_start),
    .vector_x   (b_vector_x),
    .vector_y   (b_vector_y),
    .address_r  (b_address_r),
    .address_s1 (b_address_s1),
    .address_s2 (b_address_s2)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", a_busy); else passed++;
    total++; if (a_done !== 1'b0) $display("FAIL reset_done got %0b exp 0", a_done); else passed++;
    total++; if ({a_new_dist, a_pe_ready, a_s1s2_mux} !== 48'h0)
      $display("FAIL reset_strobes got %h exp 0", {a_new_dist, a_pe_ready, a_s1s2_mux}); else passed++;
    total++; if ({a_comp_start, a_vector_x, a_vector_y, a_address_r, a_address_s1, a_address_s2} !== 39'h0)
      $display("FAIL reset_addr got %h exp 0",
               {a_comp_start, a_vector_x, a_vector_y, a_address_r, a_address_s1, a_address_s2}); else passed++;
    total++; if ({b_busy, b_done, b_address_s1} !== 10'h0)
      $display("FAIL reset_b got %h exp 0", {b_busy, b_done, b_address_s1}); else passed++;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Full 16x16 run with index-specific decode checks along the way
  task automatic test_full_run();
    int busy_cnt = 0;
    int done_at  = 0;
    @(negedge clock); a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    total++; if (a_busy !== 1'b0) $display("FAIL run_busy_edge0 got %0b exp 0", a_busy); else passed++;
    for (int n = 1; n <= 5000 && done_at == 0; n++) begin
      @(negedge clock);
      if (a_busy) busy_cnt++;
      if (a_done) done_at = n;
      case (n)
        1: begin // k=0
          total++; if ({a_vector_x, a_vector_y} !== {5'h18, 5'h17})
            $display("FAIL k0_vectors got %h exp %h", {a_vector_x, a_vector_y}, {5'h18, 5'h17}); else passed++;
          total++; if ({a_new_dist, a_comp_start, a_address_s2} !== {16'h0001, 1'b0, 10'd0})
            $display("FAIL k0_strobes got %h exp %h", {a_new_dist, a_comp_start, a_address_s2},
                     {16'h0001, 1'b0, 10'd0}); else passed++;
        end
        8: begin // k=7
          total++; if (a_s1s2_mux !== 16'h00FF) $display("FAIL k7_mux got %h exp 00ff", a_s1s2_mux); else passed++;
          total++; if (a_address_s1 !== 10'd7) $display("FAIL k7_s1 got %0d exp 7", a_address_s1); else passed++;
        end
        16: begin // k=15
          total++; if (a_new_dist !== 16'h8000) $display("FAIL k15_nd got %h exp 8000", a_new_dist); else passed++;
          total++; if (a_pe_ready !== 16'h0000) $display("FAIL k15_rdy got %h exp 0000", a_pe_ready); else passed++;
          total++; if (a_address_s2 !== 10'd0) $display("FAIL k15_s2 got %0d exp 0", a_address_s2); else passed++;
        end
        17: begin // k=16
          total++; if (a_address_s2 !== 10'd16) $display("FAIL k16_s2 got %0d exp 16", a_address_s2); else passed++;
        end
        257: begin // k=256
          total++; if ({a_new_dist, a_pe_ready, a_comp_start} !== {16'h0001, 16'h0001, 1'b1})
            $display("FAIL k256_strobes got %h exp %h", {a_new_dist, a_pe_ready, a_comp_start},
                     {16'h0001, 16'h0001, 1'b1}); else passed++;
        end
        301: begin // k=300
          total++; if (a_address_r !== 8'd44) $display("FAIL k300_r got %0d exp 44", a_address_r); else passed++;
          total++; if (a_address_s1 !== 10'd105) $display("FAIL k300_s1 got %0d exp 105", a_address_s1); else passed++;
          total++; if (a_address_s2 !== 10'd90) $display("FAIL k300_s2 got %0d exp 90", a_address_s2); else passed++;
          total++; if ({a_vector_x, a_vector_y} !== {5'd4, 5'h18})
            $display("FAIL k300_vec got %h exp %h", {a_vector_x, a_vector_y}, {5'd4, 5'h18}); else passed++;
          total++; if ({a_comp_start, a_new_dist} !== {1'b1, 16'h0})
            $display("FAIL k300_cs got %h exp %h", {a_comp_start, a_new_dist}, {1'b1, 16'h0}); else passed++;
        end
        4112: begin // k=4111, last index
          total++; if ({a_address_s1, a_address_s2} !== {10'd0, 10'd961})
            $display("FAIL klast_addr got %h exp %h", {a_address_s1, a_address_s2}, {10'd0, 10'd961}); else passed++;
        end
        default: ;
      endcase
    end
    total++; if (busy_cnt !== 4112) $display("FAIL run_busy_cycles got %0d exp 4112", busy_cnt); else passed++;
    total++; if (done_at !== 4113) $display("FAIL run_done_cycle got %0d exp 4113", done_at); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL run_busy_at_done got %0b exp 0", a_busy); else passed++;
    @(negedge clock);
    total++; if ({a_busy, a_done, a_new_dist, a_address_r, a_address_s2} !== 36'h0)
      $display("FAIL run_after_done got %h exp 0", {a_busy, a_done, a_new_dist, a_address_r, a_address_s2}); else passed++;
  endtask

  // 8x8 run: run length, address_s1 ceiling and last-index decode
  task automatic test_small();
    int busy_cnt = 0;
    int done_at  = 0;
    int max_s1   = 0;
    @(negedge clock); b_start = 1'b1;
    @(negedge clock); b_start = 1'b0;
    for (int n = 1; n <= 1000 && done_at == 0; n++) begin
      @(negedge clock);
      if (b_busy) busy_cnt++;
      if (b_done) done_at = n;
      if (int'(b_address_s1) > max_s1) max_s1 = int'(b_address_s1);
      if (n == 520) begin
        total++; if ({b_address_s2, b_vector_x, b_address_r} !== {8'd225, 4'd3, 6'd7})
          $display("FAIL small_last got %h exp %h", {b_address_s2, b_vector_x, b_address_r},
                   {8'd225, 4'd3, 6'd7}); else passed++;
      end
    end
    total++; if (busy_cnt !== 520) $display("FAIL small_busy_cycles got %0d exp 520", busy_cnt); else passed++;
    total++; if (done_at !== 521) $display("FAIL small_done_cycle got %0d exp 521", done_at); else passed++;
    total++; if (max_s1 !== 217) $display("FAIL small_max_s1 got %0d exp 217", max_s1); else passed++;
  endtask

  // start held high through DONE: second run begins after one idle cycle
  task automatic test_back_to_back();
    int busy_cnt = 0;
    int done1 = 0;
    int done2 = 0;
    @(negedge clock); b_start = 1'b1;
    @(negedge clock);
    for (int n = 1; n <= 1200 && done2 == 0; n++) begin
      @(negedge clock);
      if (b_busy) busy_cnt++;
      if (b_done) begin
        if (done1 == 0) done1 = n;
        else begin
          done2 = n;
          b_start = 1'b0;
        end
      end
      if (n == 522) begin
        total++; if ({b_busy, b_done} !== 2'b00) $display("FAIL b2b_idle got %b exp 00", {b_busy, b_done}); else passed++;
      end
      if (n == 523) begin
        total++; if ({b_busy, b_address_r, b_new_dist} !== {1'b1, 6'd0, 8'h01})
          $display("FAIL b2b_restart got %h exp %h", {b_busy, b_address_r, b_new_dist},
                   {1'b1, 6'd0, 8'h01}); else passed++;
      end
    end
    b_start = 1'b0;
    total++; if (done1 !== 521) $display("FAIL b2b_done1 got %0d exp 521", done1); else passed++;
    total++; if (done2 !== 1043) $display("FAIL b2b_done2 got %0d exp 1043", done2); else passed++;
    total++; if (busy_cnt !== 1040) $display("FAIL b2b_busy_cycles got %0d exp 1040", busy_cnt); else passed++;
    repeat (2) @(negedge clock);
    total++; if (b_busy !== 1'b0) $display("FAIL b2b_stop got %0b exp 0", b_busy); else passed++;
  endtask

  // Asynchronous reset at k=1000, then a clean restart from k=0
  task automatic test_reset_mid();
    int done_seen = 0;
    @(negedge clock); a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    repeat (1001) @(negedge clock);
    total++; if (a_address_r !== 8'd232) $display("FAIL mid_k1000_r got %0d exp 232", a_address_r); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if ({a_busy, a_new_dist, a_address_r, a_address_s1, a_vector_y} !== 40'h0)
      $display("FAIL mid_reset_clear got %h exp 0",
               {a_busy, a_new_dist, a_address_r, a_address_s1, a_vector_y}); else passed++;
    repeat (3) begin
      @(negedge clock);
      if (a_done) done_seen++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (a_done || a_busy) done_seen++;
    end
    total++; if (done_seen !== 0) $display("FAIL mid_no_done got %0d exp 0", done_seen); else passed++;
    a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    @(negedge clock);
    total++; if ({a_busy, a_address_r, a_new_dist} !== {1'b1, 8'd0, 16'h0001})
      $display("FAIL mid_restart_k0 got %h exp %h", {a_busy, a_address_r, a_new_dist},
               {1'b1, 8'd0, 16'h0001}); else passed++;
    @(negedge clock);
    total++; if ({a_address_r, a_address_s1} !== {8'd1, 10'd1})
      $display("FAIL mid_restart_k1 got %h exp %h", {a_address_r, a_address_s1}, {8'd1, 10'd1}); else passed++;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

`ifdef ME_SEARCH_ABORT_EN
  task automatic test_abort();
    int bad = 0;
    @(negedge clock); a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    repeat (50) @(negedge clock);
    a_abort = 1'b1;
    @(negedge clock); a_abort = 1'b0;
    total++; if ({a_busy, a_done, a_address_r, a_vector_y} !== 15'h0)
      $display("FAIL abort_clear got %h exp 0", {a_busy, a_done, a_address_r, a_vector_y}); else passed++;
    repeat (5) begin
      @(negedge clock);
      if (a_done || a_busy) bad++;
    end
    total++; if (bad !== 0) $display("FAIL abort_no_done got %0d exp 0", bad); else passed++;
    a_start = 1'b1; a_abort = 1'b1;
    @(negedge clock); a_start = 1'b0; a_abort = 1'b0;
    @(negedge clock);
    total++; if ({a_busy, a_address_r} !== {1'b1, 8'd0})
      $display("FAIL abort_start_wins got %h exp %h", {a_busy, a_address_r}, {1'b1, 8'd0}); else passed++;
    a_abort = 1'b1;
    @(negedge clock); a_abort = 1'b0;
    total++; if (a_busy !== 1'b0) $display("FAIL abort_second got %0b exp 0", a_busy); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_small();
    test_back_to_back();
    test_reset_mid();
`ifdef ME_SEARCH_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
